tmds_decoder: RTL



---
 rtl/tmds_decoder_if.sv | 13 +
 rtl/tmds_decoder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/tmds_decoder_if.sv
// Bundles one TMDS channel's deserializer word with its decoded pixel/control/alignment outputs.
// Flow is one word per pixel clock; there is no backpressure.
interface tmds_decoder_if;
    logic [9:0] i_tmds;
    logic [7:0] o_data;
    logic [1:0] o_ctrl;
    logic       o_de;
    logic       o_locked;
    logic       o_bitslip;

    modport master (output i_tmds, input o_data, o_ctrl, o_de, o_locked, o_bitslip);
    modport slave  (input i_tmds, output o_data, o_ctrl, o_de, o_locked, o_bitslip);
endinterface

// File: rtl/tmds_decoder.sv
// Per-channel TMDS word decoder with control-token word alignment and bitslip requests.
// Latency 1 cycle, all outputs registered; no backpressure, one word accepted every clock.
module tmds_decoder #(
    parameter int LOCK_RUN       = 16,
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int SLIP_SETTLE    = 8,
    parameter int LOSS_TIMEOUT   = 65536
) (
    input  logic          i_hdmi_clk,
    input  logic          i_reset_n,
    tmds_decoder_if.slave bus
);
    localparam int RW = $clog2(LOCK_RUN) + 1;
    localparam int TW = $clog2(SEARCH_TIMEOUT) + 1;
    localparam int SW = $clog2(SLIP_SETTLE) + 1;
    localparam int LW = $clog2(LOSS_TIMEOUT) + 1;

    localparam logic [9:0] TOK_C00 = 10'b1101010100;
    localparam logic [9:0] TOK_C01 = 10'b0010101011;
    localparam logic [9:0] TOK_C10 = 10'b0101010100;
    localparam logic [9:0] TOK_C11 = 10'b1010101011;

    typedef enum logic [1:0] {SEARCH, SLIP_WAIT, LOCKED} state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] run_q, run_d, run_n;
    logic [TW-1:0] timer_q, timer_d, timer_n;
    logic [SW-1:0] settle_q, settle_d, settle_n;
    logic [LW-1:0] loss_q, loss_d, loss_n;
    logic          prev_vld_q, prev_vld_d;
    logic [1:0]    prev_tok_q, prev_tok_d;
    logic [7:0]    data_q, data_d;
    logic [1:0]    ctrl_q, ctrl_d;
    logic          de_q, de_d;
    logic          locked_q, locked_d;
    logic          bitslip_q, bitslip_d;

    logic          is_tok;
    logic [1:0]    tok;
    logic [7:0]    d_inv;
    logic [7:0]    dec;
    logic          lock_hit;

    always_comb begin
        is_tok = 1'b1;
        tok    = 2'b00;
        case (bus.i_tmds)
            TOK_C00: tok = 2'b00;
            TOK_C01: tok = 2'b01;
            TOK_C10: tok = 2'b10;
            TOK_C11: tok = 2'b11;
            default: is_tok = 1'b0;
        endcase
    end

    // Bit 8 selects XOR vs XNOR chaining; bit 9 marks an inverted payload.
    assign d_inv = bus.i_tmds[9] ? ~bus.i_tmds[7:0] : bus.i_tmds[7:0];
    assign dec   = {d_inv[7:1] ^ d_inv[6:0] ^ {7{~bus.i_tmds[8]}}, d_inv[0]};

    always_comb begin
        run_n = RW'(0);
        if (is_tok) begin
            if (prev_vld_q && tok == prev_tok_q)
                run_n = (run_q == RW'(LOCK_RUN)) ? run_q : run_q + RW'(1);
            else
                run_n = RW'(1);
        end
    end

    assign lock_hit = is_tok && (run_n == RW'(LOCK_RUN));
    assign timer_n  = timer_q + TW'(1);
    assign settle_n = settle_q + SW'(1);
    assign loss_n   = loss_q + LW'(1);

    always_comb begin
        state_d    = state_q;
        run_d      = run_n;
        timer_d    = timer_q;
        settle_d   = settle_q;
        loss_d     = loss_q;
        prev_vld_d = prev_vld_q | is_tok;
        prev_tok_d = is_tok ? tok : prev_tok_q;
        bitslip_d  = 1'b0;

        case (state_q)
            SEARCH: begin
                if (lock_hit) begin
                    state_d = LOCKED;
                    timer_d = TW'(0);
                    loss_d  = LW'(0);
                end else if (timer_n == TW'(SEARCH_TIMEOUT)) begin
                    state_d    = SLIP_WAIT;
                    bitslip_d  = 1'b1;
                    timer_d    = TW'(0);
                    settle_d   = SW'(0);
                    run_d      = RW'(0);
                    prev_vld_d = 1'b0;
                end else begin
                    timer_d = timer_n;
                end
            end
            SLIP_WAIT: begin
                // Deserializer is realigning: whatever arrives now is garbage.
                run_d      = RW'(0);
                prev_vld_d = 1'b0;
                if (settle_n == SW'(SLIP_SETTLE)) begin
                    state_d  = SEARCH;
                    settle_d = SW'(0);
                    timer_d  = TW'(0);
                end else begin
                    settle_d = settle_n;
                end
            end
            LOCKED: begin
                if (is_tok) begin
                    loss_d = LW'(0);
                end else if (loss_n == LW'(LOSS_TIMEOUT)) begin
                    state_d    = SEARCH;
                    loss_d     = LW'(0);
                    timer_d    = TW'(0);
                    run_d      = RW'(0);
                    prev_vld_d = 1'b0;
                end else begin
                    loss_d = loss_n;
                end
            end
            default: state_d = SEARCH;
        endcase

        // Gating follows the state the word was sampled in, so the word that
        // drops lock is still delivered and the word that gains lock is not.
        locked_d = (state_d == LOCKED);
        data_d   = 8'h00;
        ctrl_d   = 2'b00;
        de_d     = 1'b0;
        if (state_q == LOCKED) begin
            if (is_tok) begin
                ctrl_d = tok;
            end else begin
                ctrl_d = ctrl_q;
                data_d = dec;
                de_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge i_hdmi_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= SEARCH;
            run_q      <= '0;
            timer_q    <= '0;
            settle_q   <= '0;
            loss_q     <= '0;
            prev_vld_q <= 1'b0;
            prev_tok_q <= 2'b00;
            data_q     <= 8'h00;
            ctrl_q     <= 2'b00;
            de_q       <= 1'b0;
            locked_q   <= 1'b0;
            bitslip_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            timer_q    <= timer_d;
            settle_q   <= settle_d;
            loss_q     <= loss_d;
            prev_vld_q <= prev_vld_d;
            prev_tok_q <= prev_tok_d;
            data_q     <= data_d;
            ctrl_q     <= ctrl_d;
            de_q       <= de_d;
            locked_q   <= locked_d;
            bitslip_q  <= bitslip_d;
        end
    end

    assign bus.o_data    = data_q;
    assign bus.o_ctrl    = ctrl_q;
    assign bus.o_de      = de_q;
    assign bus.o_locked  = locked_q;
    assign bus.o_bitslip = bitslip_q;
endmodule
